// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: operation encodings and FSM states.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/mux2x1.sv
// Single-bit 2:1 multiplexer cell: y = sel ? b : a.
module mux2x1 (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/shift_step.sv
// One-position shift/rotate of a WIDTH-bit word, built from mux2x1 cells.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out
);

  logic             is_sll;
  logic             fill_sign_or_rot;
  logic             msb_fill;
  logic [WIDTH-1:0] left_val;
  logic [WIDTH-1:0] right_val;

  assign is_sll = (op == OP_SLL);

  // Bit shifted into the MSB on right moves: 0 for SRL, sign for SRA, LSB for ROR.
  mux2x1 u_fill_sel (
    .a   (in[WIDTH-1]),
    .b   (in[0]),
    .sel (op[0]),
    .y   (fill_sign_or_rot)
  );

  mux2x1 u_fill_zero (
    .a   (1'b0),
    .b   (fill_sign_or_rot),
    .sel (op[1]),
    .y   (msb_fill)
  );

  assign left_val  = {in[WIDTH-2:0], 1'b0};
  assign right_val = {msb_fill, in[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2x1 u_dir (
      .a   (right_val[i]),
      .b   (left_val[i]),
      .sel (is_sll),
      .y   (out[i])
    );
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: applies shift_step once per clock, shamt times, then strobes done.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] step_out;
  logic             accept;

  // A new command can only be taken when no shift is in flight.
  assign accept = start && (state_q != SHIFT);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .in  (result_q),
    .op  (op_q),
    .out (step_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      op_q     <= OP_SLL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      op_q     <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (shamt == '0) ? DONE : SHIFT;
        else       state_d = IDLE;
      end
      SHIFT:   state_d = (cnt_q == AMT_W'(1)) ? DONE : SHIFT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    result_d = result_q;
    op_d     = op_q;
    if (accept) begin
      cnt_d    = shamt;
      result_d = data_in;
      op_d     = op;
    end else if (state_q == SHIFT) begin
      cnt_d    = cnt_q - AMT_W'(1);
      result_d = step_out;
    end
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
  end

  assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: each accepted command queues its expected result/timing.
module tb_shift_sequencer;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [15:0] data_in;
  logic [3:0]  shamt;
  logic        busy;
  logic        done;
  logic [15:0] result;

  typedef struct {
    logic [15:0] res;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   busy_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  shift_sequencer #(.WIDTH(16), .AMT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .data_in (data_in),
    .shamt   (shamt),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model(logic [15:0] d, logic [1:0] o, int k);
    case (o)
      SLL:     return d << k;
      SRL:     return d >> k;
      SRA:     return 16'($signed(d) >>> k);
      default: return (d >> k) | (d << (16 - k));
    endcase
  endfunction

  // Output monitor: every done strobe is matched against the oldest queued command.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    if (reset === 1'b1) begin
      busy_cnt = 0;
    end else if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("result", 32'(result), 32'(mon_e.res));
        chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("busy_cycles", 32'(busy_cnt), 32'(mon_e.busy));
      end
      busy_cnt = 0;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge with inputs scrambled.
  task automatic issue(input logic [15:0] d, input logic [1:0] o, input int k,
                       input logic [15:0] exp);
    exp_t e;
    data_in = d;
    op      = o;
    shamt   = 4'(k);
    start   = 1'b1;
    e.res   = exp;
    e.cyc   = cyc + 1 + k;
    e.busy  = k;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    data_in = 16'($urandom);
    op      = 2'($urandom);
    shamt   = 4'($urandom);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk(tag, 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
    if (done !== 1'b1) chk("wait_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op      = SLL;
    data_in = '0;
    shamt   = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    issue(16'h0001, SLL, 4, 16'h0010);
    wait_drain("drain_sll4");
    issue(16'h8000, SRA, 15, 16'hFFFF);
    wait_drain("drain_sra15");
    issue(16'h8000, SRL, 15, 16'h0001);
    wait_drain("drain_srl15");
    issue(16'h0001, ROR, 1, 16'h8000);
    wait_drain("drain_ror1");
    issue(16'hABCD, SLL, 0, 16'hABCD);
    wait_drain("drain_shamt0");
    chk("idle_hold", 32'(result), 32'hABCD);

    // A second start during SHIFT must be dropped.
    issue(16'h0001, SLL, 3, 16'h0008);
    data_in = 16'hFFFF;
    op      = SRL;
    shamt   = 4'd2;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_drain("drain_ignore");
    repeat (3) @(negedge clk);
    chk("ignore_hold", 32'(result), 32'h0008);

    // Reset at E2 of an 8-step shift: no done, outputs back to reset values.
    issue(16'h0F0F, SLL, 8, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    chk("abort_result", 32'(result), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    repeat (10) @(negedge clk);
    issue(16'h0003, SLL, 2, 16'h000C);
    wait_drain("drain_after_abort");

    // Reset beats a simultaneous start.
    data_in = 16'h1234;
    op      = SLL;
    shamt   = 4'd0;
    start   = 1'b1;
    reset   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reset   = 1'b0;
    chk("rst_start_result", 32'(result), 32'h0);
    chk("rst_start_done", 32'(done), 32'h0);
    repeat (3) @(negedge clk);

    // Back-to-back: second command accepted in the first command's DONE cycle.
    issue(16'h00F0, SRL, 4, 16'h000F);
    wait_done();
    issue(16'h0F00, SLL, 0, 16'h0F00);
    wait_drain("drain_b2b");

    issue(16'h1234, ROR, 4, 16'h4123);
    wait_drain("drain_ror4");

    for (int n = 0; n < 8; n++) begin
      logic [15:0] d;
      logic [1:0]  o;
      int          k;
      d = 16'($urandom);
      o = 2'($urandom);
      k = int'($urandom_range(0, 15));
      issue(d, o, k, model(d, o, k));
      wait_drain("drain_rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift controller that drives a single one-position shift stage repeatedly to perform 16-bit shifts and rotates of 0–15 positions. It accepts a shift command with a start pulse and steps the working register once per clock. It raises a one-cycle done strobe when the result is ready. It sits beside the ALU as the low-area alternative to the full log-stage barrel shifter, for shift-class instructions in the multi-cycle datapath.

## Interface
Parameters:
- WIDTH, 16, data width.
- AMT_W, 4, shift-amount width; maximum shift is 2**AMT_W-1.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, command strobe; sampled only when the block can accept.
- op, input, 2, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- data_in, input, WIDTH, operand; sampled on the accept edge.
- shamt, input, AMT_W, shift amount; sampled on the accept edge.
- busy, output, 1, high while state is SHIFT.
- done, output, 1, one-cycle strobe; result is valid while done is high.
- result, output, WIDTH, working register; holds its value until the next accept.

## Operation
- States: IDLE, SHIFT, DONE.
- Accept condition: start=1 while state is IDLE or DONE. start in SHIFT is ignored, not queued.
- On accept, latch op, set result←data_in and cnt←shamt.
  - If shamt=0, next state is DONE.
  - Otherwise, next state is SHIFT.
- Each edge in SHIFT:
  - result←step(result, op) and cnt←cnt-1.
  - When cnt=1 before the edge, next state is DONE; otherwise stay in SHIFT.
- step(), a one-position operation:
  - SLL: {r[14:0],0}.
  - SRL: {0,r[15:1]}.
  - SRA: {r[15],r[15:1]}.
  - ROR: {r[0],r[15:1]}.
- DONE lasts exactly one cycle. Next state is IDLE, or SHIFT/DONE if a new start is accepted in that cycle.
- result changes only on an accept edge or a SHIFT edge. It is stable in IDLE and DONE.
- Latched op and shamt are not affected by input changes after accept.

## Timing
- Reset values: state IDLE, cnt 0, result 0, busy 0, done 0.
- Call the accept edge E0. done is high in the cycle following edge E_max(shamt,1)-… more precisely:
  - shamt=k>0: k SHIFT edges E1..Ek, with done high in the cycle after Ek. Latency is k+1 edges from accept, counting E0.
  - shamt=0: done is high in the cycle after E0, and result equals data_in.
- busy is high in the cycles after E0..E(k-1) for k>0. It is never high for shamt=0.
- Back-to-back: start in a DONE cycle is accepted on that cycle's edge. done drops in the next cycle unless shamt=0, in which case done stays high for the new result. The old result remains visible during its DONE cycle.
- reset asserted mid-operation aborts with no done pulse. All outputs return to their reset values on that edge.
- reset and start on the same edge: reset wins.
- Shift of 15 with SRA saturates to all sign bits. ROR by k equals a right rotate by k mod 16.

## Structure
- Shared package `shift_pkg` holds:
  - the op encodings OP_SLL, OP_SRL, OP_SRA, OP_ROR;
  - the state typedef {IDLE, SHIFT, DONE}.
- The one-position operation lives in the combinational sub-module `shift_step` (inputs in, op; output out), built from the codebase's mux2x1 cells.
- `shift_sequencer` contains only the FSM, the counter and the result register.

## Test plan
- SLL data_in=0x0001, shamt=4 → busy for 4 cycles; done in the cycle after edge E4; result=0x0010.
- SRA data_in=0x8000, shamt=15 → result=0xFFFF after 15 shift edges; SRL of the same operand → 0x0001.
- ROR data_in=0x0001, shamt=1 → result=0x8000, done after E1; shamt=0 with data_in=0xABCD → done after E0, result=0xABCD, busy never high.
- start with op=SLL, shamt=3 pulsed again during SHIFT with different data → ignored; original result 0x0008 from 0x0001.
- reset asserted at edge E2 of a shamt=8 operation → no done; result=0, state IDLE; next command executes normally.
- Back-to-back: start accepted in the DONE cycle (0x00F0 SRL 4, then 0x0F00 SLL 0) → first result 0x000F visible for one cycle; done high again the next cycle with 0x0F00.
